// File: rtl/steer_en_ctrl.sv
// Rider-presence and steering-enable sequencer.
// Samples load cells and gates rider_off/en_steer.
module steer_en_ctrl #(
   parameter logic [12:0] MIN_RIDER_WT = 13'h0200,
   parameter int          TMR_BITS     = 26
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vld,
   input  logic [11:0] lft_ld,
   input  logic [11:0] rght_ld,
   output logic        rider_off,
   output logic        en_steer,
   output logic [11:0] ld_cell_diff
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      WAIT  = 2'b01,
      STEER = 2'b10
   } state_t;

   state_t state;
   state_t nxt;

   logic [11:0] lft_q;
   logic [11:0] rght_q;

   logic [12:0] sum;
   logic [12:0] diff;
   logic [12:0] adiff13;
   logic [11:0] adiff;
   logic [12:0] adiff_x;

   logic sum_lt_min;
   logic diff_gt_1_4;
   logic diff_gt_15_16;

   logic [TMR_BITS-1:0] tmr;
   logic                tmr_full;
   logic                tmr_clr;
   logic                tmr_inc;

   logic rider_off_d;
   logic en_steer_d;

   // Capture a new load-cell pair on each valid strobe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lft_q  <= '0;
         rght_q <= '0;
      end else if (vld) begin
         lft_q  <= lft_ld;
         rght_q <= rght_ld;
      end
   end

   // Sum, difference, magnitude and saturated difference
   always_comb begin
      sum     = {1'b0, lft_q} + {1'b0, rght_q};
      diff    = {1'b0, lft_q} - {1'b0, rght_q};
      adiff13 = diff[12] ? (13'd0 - diff) : diff;
      adiff   = adiff13[11:0];
      adiff_x = {1'b0, adiff};
      if (diff[12] == diff[11])
         ld_cell_diff = diff[11:0];
      else if (diff[12])
         ld_cell_diff = 12'h800;
      else
         ld_cell_diff = 12'h7FF;
   end

   // Rider-weight and balance thresholds
   always_comb begin
      sum_lt_min    = (sum < MIN_RIDER_WT);
      diff_gt_1_4   = (adiff_x > (sum >> 2));
      diff_gt_15_16 = (adiff_x > (sum - (sum >> 4)));
   end

   assign tmr_full = &tmr;

   // State register; unused encodings fall back to IDLE
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= nxt;
   end

   // Next state and timer control, priority ordered
   always_comb begin
      nxt     = IDLE;
      tmr_clr = 1'b0;
      tmr_inc = 1'b0;
      case (state)
         IDLE: begin
            if (!sum_lt_min) begin
               nxt     = WAIT;
               tmr_clr = 1'b1;
            end else begin
               nxt = IDLE;
            end
         end
         WAIT: begin
            if (sum_lt_min) begin
               nxt = IDLE;
            end else if (diff_gt_1_4) begin
               nxt     = WAIT;
               tmr_clr = 1'b1;
            end else if (tmr_full) begin
               nxt = STEER;
            end else begin
               nxt     = WAIT;
               tmr_inc = 1'b1;
            end
         end
         STEER: begin
            if (sum_lt_min) begin
               nxt = IDLE;
            end else if (diff_gt_15_16) begin
               nxt     = WAIT;
               tmr_clr = 1'b1;
            end else begin
               nxt = STEER;
            end
         end
         default: nxt = IDLE;
      endcase
   end

   // Steer-enable timer, saturating at all-ones
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         tmr <= '0;
      else if (tmr_clr)
         tmr <= '0;
      else if (tmr_inc && !tmr_full)
         tmr <= tmr + 1'b1;
   end

   // Output decode from the next state
   always_comb begin
      rider_off_d = (nxt == IDLE);
      en_steer_d  = (nxt == STEER);
   end

   // Registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rider_off <= 1'b1;
         en_steer  <= 1'b0;
      end else begin
         rider_off <= rider_off_d;
         en_steer  <= en_steer_d;
      end
   end

endmodule
